// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types and defaults for the PWM tick generator.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Default width of period, duty and counter.
    localparam int unsigned c_CNT_W = 8;

    // Controller states, explicitly encoded.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } pwm_state_t;

endpackage
`default_nettype wire

// File: rtl/edge_detect_rise.sv
`default_nettype none
// ============================================================================
// Module      : edge_detect_rise
// Description : One-cycle pulse on each rising edge of a level that is already
//               in the clk_in domain. A level held high yields one pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_detect_rise (
    input  logic clk_in,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise
);

    logic r_prev;

    // Remember last cycle's level so a rise can be spotted.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= sig_in;
        end
    end

    assign rise = sig_in & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/pwm_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : pwm_tick_gen
// Description : PWM generator counting rising edges of a divided clock, with
//               double-buffered period/duty that switch only at boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_tick_gen
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = c_CNT_W
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             tick_src,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
    output logic             pwm_out,
    output logic             period_start,
    output logic             busy
);

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pwm_state_t       r_state,  w_state_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [CNT_W-1:0] r_per_a,  w_per_a_nxt;
    logic [CNT_W-1:0] r_duty_a, w_duty_a_nxt;
    logic [CNT_W-1:0] r_per_s,  w_per_s_nxt;
    logic [CNT_W-1:0] r_duty_s, w_duty_s_nxt;
    logic             r_pend,   w_pend_nxt;
    logic             r_pwm,    w_pwm_nxt;
    logic             r_ps,     w_ps_nxt;
    logic             w_tick;
    logic             w_xfer;
    logic             w_boundary;

    edge_detect_rise u_tick_edge (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .sig_in (tick_src),
        .rise   (w_tick)
    );

    assign cfg_ready    = ~r_pend;
    assign w_xfer       = cfg_valid & ~r_pend;
    assign w_boundary   = w_tick & (r_cnt == r_per_a);
    assign pwm_out      = r_pwm;
    assign period_start = r_ps;
    assign busy         = (r_state != ST_IDLE);

    // Next-state, counter, config buffering and output decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_per_a_nxt  = r_per_a;
        w_duty_a_nxt = r_duty_a;
        w_per_s_nxt  = r_per_s;
        w_duty_s_nxt = r_duty_s;
        w_pend_nxt   = r_pend;
        w_ps_nxt     = 1'b0;

        if (r_state == ST_IDLE) begin
            // Idle: config goes straight to the active set.
            if (w_xfer) begin
                w_per_a_nxt  = cfg_period;
                w_duty_a_nxt = cfg_duty;
            end
        end else begin
            // Counting runs in both RUN and STOP.
            if (w_tick) begin
                if (w_boundary) begin
                    w_cnt_nxt = '0;
                    if (r_pend) begin
                        w_per_a_nxt  = r_per_s;
                        w_duty_a_nxt = r_duty_s;
                        w_pend_nxt   = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            // A transfer needs pend low, so it never collides with a load.
            if (w_xfer) begin
                w_per_s_nxt  = cfg_period;
                w_duty_s_nxt = cfg_duty;
                w_pend_nxt   = 1'b1;
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                    w_ps_nxt    = 1'b1;
                end
            end
            ST_RUN: begin
                w_ps_nxt = w_boundary;
                if (!en) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // A returning enable wins over the final boundary.
                if (en) begin
                    w_state_nxt = ST_RUN;
                    w_ps_nxt    = w_boundary;
                end else if (w_boundary) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_pwm_nxt = (w_state_nxt != ST_IDLE) && (w_cnt_nxt < w_duty_a_nxt);
    end

    // State and datapath registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_per_a  <= '0;
            r_duty_a <= '0;
            r_per_s  <= '0;
            r_duty_s <= '0;
            r_pend   <= 1'b0;
            r_pwm    <= 1'b0;
            r_ps     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_per_a  <= w_per_a_nxt;
            r_duty_a <= w_duty_a_nxt;
            r_per_s  <= w_per_s_nxt;
            r_duty_s <= w_duty_s_nxt;
            r_pend   <= w_pend_nxt;
            r_pwm    <= w_pwm_nxt;
            r_ps     <= w_ps_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_tick_gen
// Description : Self-checking bench for pwm_tick_gen with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_tick_gen;

    logic       clk_in;
    logic       rst_n;
    logic       tick_src;
    logic       en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_period;
    logic [7:0] cfg_duty;
    logic       pwm_out;
    logic       period_start;
    logic       busy;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    // Behavioural model: mode 0 idle, 1 run, 2 stop; position within period.
    int m_mode, m_pos, m_per, m_duty, m_sper, m_sduty;
    bit m_pend, m_last, m_pwm, m_ps;

    pwm_tick_gen #(.CNT_W(8)) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .tick_src     (tick_src),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .busy         (busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_per = 0; m_duty = 0; m_sper = 0; m_sduty = 0;
        m_pend = 0; m_last = 0; m_pwm = 0; m_ps = 0;
    endtask

    // One clock of the model, from the inputs present at the edge.
    task automatic model_step();
        bit rise, acc, bnd;
        rise   = tick_src && !m_last;
        m_last = tick_src;
        acc    = cfg_valid && !m_pend;
        m_ps   = 0;
        if (m_mode == 0) begin
            if (acc) begin m_per = cfg_period; m_duty = cfg_duty; end
            if (en) begin m_mode = 1; m_pos = 0; m_ps = 1; end
        end else begin
            bnd = rise && (m_pos == m_per);
            if (rise) begin
                if (bnd) begin
                    m_pos = 0;
                    if (m_pend) begin m_per = m_sper; m_duty = m_sduty; m_pend = 0; end
                end else begin
                    m_pos++;
                end
            end
            if (acc) begin m_sper = cfg_period; m_sduty = cfg_duty; m_pend = 1; end
            if (en) begin
                m_mode = 1;
                if (bnd) m_ps = 1;
            end else if (m_mode == 1) begin
                m_mode = 2;
                if (bnd) m_ps = 1;
            end else if (bnd) begin
                m_mode = 0;
            end
        end
        m_pwm = (m_mode != 0) && (m_pos < m_duty);
    endtask

    task automatic step();
        @(posedge clk_in);
        model_step();
        #1;
    endtask

    // One tick of a divide-by-4 source; returns outputs just after the counted edge.
    task automatic tick4(output logic p, output logic s);
        tick_src = 1'b1; step();
        p = pwm_out; s = period_start;
        step();
        tick_src = 1'b0; step(); step();
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk_in) begin
        if (chk_on && rst_n) begin
            chk("pwm_out", pwm_out, m_pwm);
            chk("period_start", period_start, m_ps);
            chk("busy", busy, m_mode != 0);
            chk("cfg_ready", cfg_ready, !m_pend);
        end
    end

    initial begin
        logic p, s;
        int   n;
        rst_n = 1'b0; tick_src = 1'b0; en = 1'b0;
        cfg_valid = 1'b0; cfg_period = '0; cfg_duty = '0;
        model_reset();
        #1;
        chk("rst_pwm", pwm_out, 0);
        chk("rst_ps", period_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cfg_ready, 1);
        repeat (2) @(posedge clk_in);
        #1 rst_n = 1'b1;
        chk_on = 1;

        // Idle config goes straight to active; no pending.
        cfg_valid = 1'b1; cfg_period = 8'd3; cfg_duty = 8'd1; step();
        cfg_valid = 1'b0;
        chk("idle_cfg_ready", cfg_ready, 1);

        // Enable latency.
        en = 1'b1; step();
        chk("en_busy", busy, 1);
        chk("en_ps", period_start, 1);
        chk("en_pwm", pwm_out, 1);
        step();

        // Basic PWM: 1 high tick out of 4.
        for (int k = 1; k <= 12; k++) begin
            tick4(p, s);
            chk("basic_pwm", p, (k % 4) == 0);
            chk("basic_ps", s, (k % 4) == 0);
        end

        // Level held high counts once.
        tick_src = 1'b1; repeat (10) step();
        tick_src = 1'b0; step();
        chk("hold_pwm", pwm_out, 0);
        tick4(p, s); chk("hold_ps1", s, 0);
        tick4(p, s); chk("hold_ps2", s, 0);
        tick4(p, s); chk("hold_ps3", s, 1);

        // Config change in RUN waits for the boundary.
        cfg_valid = 1'b1; cfg_period = 8'd1; cfg_duty = 8'd1; step();
        cfg_valid = 1'b0;
        chk("cfg_ready_low", cfg_ready, 0);
        tick4(p, s); tick4(p, s); tick4(p, s);
        chk("cfg_ready_still_low", cfg_ready, 0);
        chk("cfg_old_pwm", p, 0);
        tick4(p, s);
        chk("cfg_load_pwm", p, 1);
        chk("cfg_load_ps", s, 1);
        chk("cfg_ready_back", cfg_ready, 1);
        tick4(p, s);
        chk("new_low_pwm", p, 0);
        chk("new_low_ps", s, 0);
        tick4(p, s);
        chk("new_bnd_pwm", p, 1);
        chk("new_bnd_ps", s, 1);

        // Back to period 3, then graceful stop from cnt=1.
        cfg_valid = 1'b1; cfg_period = 8'd3; cfg_duty = 8'd1; step();
        cfg_valid = 1'b0;
        tick4(p, s);
        tick4(p, s); chk("reload_ps", s, 1);
        tick4(p, s);
        en = 1'b0; step();
        chk("stop_busy", busy, 1);
        tick4(p, s); tick4(p, s);
        chk("stop_busy_mid", busy, 1);
        tick4(p, s);
        chk("stop_end_busy", busy, 0);
        chk("stop_end_pwm", p, 0);
        chk("stop_end_ps", s, 0);

        // Re-raise enable in STOP: counting continues without a gap.
        en = 1'b1; step(); step();
        tick4(p, s);
        en = 1'b0; step();
        tick4(p, s);
        en = 1'b1; step();
        chk("rerun_busy", busy, 1);
        chk("rerun_ps", period_start, 0);
        tick4(p, s); chk("rerun_ps_mid", s, 0);
        tick4(p, s); chk("rerun_ps_bnd", s, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 2) == 0) tick_src = ~tick_src;
            cfg_valid  = ($urandom_range(0, 5) == 0);
            cfg_period = 8'($urandom_range(0, 4));
            cfg_duty   = 8'($urandom_range(0, 6));
            step();
        end
        cfg_valid = 1'b0;

        // Drain to IDLE, then reset while the output is high.
        en = 1'b0;
        n  = 0;
        while (busy && n < 500) begin
            tick_src = ~tick_src; step(); n++;
        end
        chk("drain_idle", busy, 0);
        cfg_valid = 1'b1; cfg_period = 8'd3; cfg_duty = 8'd2; step();
        cfg_valid = 1'b0; en = 1'b1; step();
        chk("prereset_pwm", pwm_out, 1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_pwm", pwm_out, 0);
        chk("midrst_ps", period_start, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cfg_ready, 1);
        en = 1'b0;
        @(posedge clk_in);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            tick_src = ~tick_src;
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_period = 8'($urandom_range(0, 3));
            cfg_duty = 8'($urandom_range(0, 9));
            step();
        end
        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
